// File: rtl/sub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// sub_pipe_pkg
// Shared constants and types for the two-stage pipelined subtractor.
//   SUB_WIDTH / SUB_WIDTH1 / SUB_WIDTH2 : default total, LSB-segment and
//                                         MSB-segment widths
//   sub_s1_t                            : stage-1 payload {b1, dl, bm, dm, xs, ys}
// Optional feature macro: SUB_PIPE_OVF_EN adds the xs/ys sign bits to the
// stage-1 payload so the signed-overflow flag can be produced in stage 2.
// ---------------------------------------------------------------------------
package sub_pipe_pkg;

  localparam int SUB_WIDTH  = 15;
  localparam int SUB_WIDTH1 = 7;
  localparam int SUB_WIDTH2 = 8;

  // dl/b1: LSB difference and its borrow-out; dm/bm: raw MSB difference and
  // its borrow-out, before the LSB borrow is folded in by stage 2.
  typedef struct packed {
    logic                  b1;
    logic [SUB_WIDTH1-1:0] dl;
    logic                  bm;
    logic [SUB_WIDTH2-1:0] dm;
`ifdef SUB_PIPE_OVF_EN
    logic                  xs;
    logic                  ys;
`endif
  } sub_s1_t;

endpackage

// File: rtl/sub_pipe_if.sv
// ---------------------------------------------------------------------------
// sub_pipe_if
// Operand/result bus of sub_pipe with valid/ready handshakes on both ends.
//   x, y, in_valid  : operands and their valid   (producer -> sub_pipe)
//   in_ready        : sub_pipe can take operands (sub_pipe -> producer)
//   diff, borrow    : result and unsigned borrow (sub_pipe -> consumer)
//   ovf             : signed overflow, only with SUB_PIPE_OVF_EN
//   out_valid       : result valid               (sub_pipe -> consumer)
//   out_ready       : consumer takes the result  (consumer -> sub_pipe)
// Modports: master = producer/consumer side, slave = sub_pipe side.
// ---------------------------------------------------------------------------
interface sub_pipe_if #(
  parameter int WIDTH = sub_pipe_pkg::SUB_WIDTH
) ();

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SUB_PIPE_OVF_EN
  logic             ovf;
`endif
  logic             out_valid;
  logic             out_ready;

  modport master (
    output x, y, in_valid, out_ready,
`ifdef SUB_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, diff, borrow, out_valid
  );

  modport slave (
    input  x, y, in_valid, out_ready,
`ifdef SUB_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, diff, borrow, out_valid
  );

endinterface

// File: rtl/sub_pipe_seg.sv
// ---------------------------------------------------------------------------
// sub_pipe_seg
// Unsigned N-bit segment subtractor with borrow-in and borrow-out:
//   {bout_o, d_o} = {0, a_i} - {0, b_i} - bin_i
// Ports: a_i (minuend), b_i (subtrahend), bin_i (borrow in),
//        d_o (difference mod 2^N), bout_o (borrow out).
// ---------------------------------------------------------------------------
module sub_pipe_seg #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         bin_i,
  output logic [N-1:0] d_o,
  output logic         bout_o
);

  logic [N:0] res;

  // The extra MSB goes to 1 exactly when the true result is negative.
  assign res = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, bin_i};
  assign {bout_o, d_o} = res;

endmodule

// File: rtl/sub_pipe.sv
// ---------------------------------------------------------------------------
// sub_pipe
// Two-stage pipelined subtractor, diff = x - y mod 2^WIDTH. Stage 1 subtracts
// the LSB and MSB segments independently; stage 2 folds the registered LSB
// borrow into the MSB segment. Two-entry pipeline with full back-pressure.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears control and data)
//   bus   : sub_pipe_if.slave (x, y, in_valid, in_ready, diff, borrow,
//           [ovf], out_valid, out_ready)
// Optional feature macro: SUB_PIPE_OVF_EN compiles in the signed-overflow
// output, its sign-bit registers and the overflow logic.
// ---------------------------------------------------------------------------
module sub_pipe
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH  = SUB_WIDTH,
  parameter int WIDTH1 = SUB_WIDTH1,
  parameter int WIDTH2 = SUB_WIDTH2
) (
  input  logic     clk,
  input  logic     rst_n,
  sub_pipe_if.slave bus
);

  // Elaboration guards: segment widths must tile the operand, and the
  // stage-1 payload layout is taken from the package struct.
  generate
    if (WIDTH != WIDTH1 + WIDTH2) begin : g_width_sum_chk
      $error("sub_pipe: WIDTH (%0d) must equal WIDTH1 + WIDTH2 (%0d)",
             WIDTH, WIDTH1 + WIDTH2);
    end
    if ((WIDTH1 != SUB_WIDTH1) || (WIDTH2 != SUB_WIDTH2)) begin : g_payload_chk
      $error("sub_pipe: WIDTH1/WIDTH2 must match the sub_s1_t payload layout");
    end
  endgenerate

`ifdef SUB_PIPE_OVF_EN
  // Operands of differing sign overflow when the result sign differs from x.
  function automatic logic ovf_detect(input logic xs, input logic ys,
                                      input logic rs);
    return (xs ^ ys) & (rs ^ xs);
  endfunction
`endif

  logic             vld_p1_q;
  logic             vld_p2_q;
  logic             adv_p1;
  logic             adv_p2;
  logic             accept;

  sub_s1_t          s1_d;
  sub_s1_t          s1_q;

  logic [WIDTH1-1:0] dl_d;
  logic              b1_d;
  logic [WIDTH2-1:0] dm_d;
  logic              bm_d;

  logic [WIDTH2-1:0] dm2;
  logic              bm2;

  logic [WIDTH-1:0]  diff_p2_d;
  logic [WIDTH-1:0]  diff_p2_q;
  logic              borrow_p2_d;
  logic              borrow_p2_q;
`ifdef SUB_PIPE_OVF_EN
  logic              ovf_p2_d;
  logic              ovf_p2_q;
`endif

  // A stage may load when it is empty or its contents move on this edge.
  assign adv_p2       = ~vld_p2_q | bus.out_ready;
  assign adv_p1       = ~vld_p1_q | adv_p2;
  assign accept       = bus.in_valid & adv_p1;
  assign bus.in_ready = adv_p1;

  // ---- stage 1: independent segment subtracts ----
  sub_pipe_seg #(.N(WIDTH1)) u_seg_lsb (
    .a_i   (bus.x[WIDTH1-1:0]),
    .b_i   (bus.y[WIDTH1-1:0]),
    .bin_i (1'b0),
    .d_o   (dl_d),
    .bout_o(b1_d)
  );

  sub_pipe_seg #(.N(WIDTH2)) u_seg_msb (
    .a_i   (bus.x[WIDTH-1:WIDTH1]),
    .b_i   (bus.y[WIDTH-1:WIDTH1]),
    .bin_i (1'b0),
    .d_o   (dm_d),
    .bout_o(bm_d)
  );

  always_comb begin
    s1_d    = '0;
    s1_d.b1 = b1_d;
    s1_d.dl = dl_d;
    s1_d.bm = bm_d;
    s1_d.dm = dm_d;
`ifdef SUB_PIPE_OVF_EN
    s1_d.xs = bus.x[WIDTH-1];
    s1_d.ys = bus.y[WIDTH-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      s1_q     <= '0;
    end else if (adv_p1) begin
      vld_p1_q <= accept;
      if (accept) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---- stage 2: fold the LSB borrow into the MSB segment ----
  sub_pipe_seg #(.N(WIDTH2)) u_seg_dec (
    .a_i   (s1_q.dm),
    .b_i   ({WIDTH2{1'b0}}),
    .bin_i (s1_q.b1),
    .d_o   (dm2),
    .bout_o(bm2)
  );

  // bm and bm2 cannot both be set: bm2 needs dm = 0, which with bm = 1
  // would require xM - yM = -2^WIDTH2, impossible for WIDTH2-bit operands.
  assign diff_p2_d   = {dm2, s1_q.dl};
  assign borrow_p2_d = s1_q.bm | bm2;
`ifdef SUB_PIPE_OVF_EN
  assign ovf_p2_d    = ovf_detect(s1_q.xs, s1_q.ys, dm2[WIDTH2-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q    <= 1'b0;
      diff_p2_q   <= '0;
      borrow_p2_q <= 1'b0;
`ifdef SUB_PIPE_OVF_EN
      ovf_p2_q    <= 1'b0;
`endif
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        diff_p2_q   <= diff_p2_d;
        borrow_p2_q <= borrow_p2_d;
`ifdef SUB_PIPE_OVF_EN
        ovf_p2_q    <= ovf_p2_d;
`endif
      end
    end
  end

  // ---- outputs ----
  assign bus.out_valid = vld_p2_q;
  assign bus.diff      = diff_p2_q;
  assign bus.borrow    = borrow_p2_q;
`ifdef SUB_PIPE_OVF_EN
  assign bus.ovf       = ovf_p2_q;
`endif

endmodule

// File: tb/tb_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_sub_pipe
// Self-checking bench for sub_pipe: directed vector table, back-pressure and
// mid-stream reset sequences, and a randomized run against a queue-based
// reference model. Overflow checks are compiled in with SUB_PIPE_OVF_EN.
// ---------------------------------------------------------------------------
module tb_sub_pipe;

  localparam int W    = 15;
  localparam int FULL = 32768;
  localparam int HALF = 16384;

  logic clk;
  logic rst_n;

  sub_pipe_if #(.WIDTH(W)) bus ();

  sub_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    int           e;
  } ent_t;

  // Arithmetic reference: unsigned wrap, unsigned compare, signed range test.
  function automatic ent_t ref_sub(input int unsigned x, input int unsigned y);
    ent_t r;
    int sx, sy, sd;
    r.d = W'((x - y) % FULL);
    r.b = (x < y);
    sx  = (x >= HALF) ? int'(x) - FULL : int'(x);
    sy  = (y >= HALF) ? int'(y) - FULL : int'(y);
    sd  = sx - sy;
    r.o = (sd > HALF - 1) || (sd < -HALF);
    r.e = 0;
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } vec_t;

  vec_t vecs[10];
  ent_t q[$];

  initial begin
    int   acc, got, ec;
    logic rdy, pop, push, exp_v, exp_rdy;
    ent_t r;

    vecs[0] = '{15'd100,   15'd30,    15'd70,    1'b0, 1'b0};
    vecs[1] = '{15'h0080,  15'h0001,  15'h007F,  1'b0, 1'b0};
    vecs[2] = '{15'h0000,  15'h0001,  15'h7FFF,  1'b1, 1'b0};
    vecs[3] = '{15'h4000,  15'h0001,  15'h3FFF,  1'b0, 1'b1};
    vecs[4] = '{15'h7FFF,  15'h7FFF,  15'h0000,  1'b0, 1'b0};
    vecs[5] = '{15'h3FFF,  15'h4000,  15'h7FFF,  1'b1, 1'b1};
    vecs[6] = '{15'h0100,  15'h0080,  15'h0080,  1'b0, 1'b0};
    vecs[7] = '{15'h0000,  15'h7FFF,  15'h0001,  1'b1, 1'b0};
    vecs[8] = '{15'h0001,  15'h0080,  15'h7F81,  1'b1, 1'b0};
    vecs[9] = '{15'h4000,  15'h7FFF,  15'h4001,  1'b1, 1'b0};

    // Reset state
    rst_n         = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
`ifdef SUB_PIPE_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time with out_ready high
    for (int i = 0; i < 10; i++) begin
      bus.x         = vecs[i].x;
      bus.y         = vecs[i].y;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_latency", i), bus.out_valid, 0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_diff", i), bus.diff, vecs[i].d);
      chk($sformatf("vec%0d_borrow", i), bus.borrow, vecs[i].b);
`ifdef SUB_PIPE_OVF_EN
      chk($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].o);
`endif
    end
    @(posedge clk);
    #1;
    chk("drain_empty", bus.out_valid, 0);

    // Back-pressure: (i, 1) for i = 10..14 with out_ready low
    acc           = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.x        = W'(10 + acc);
      bus.y        = 15'd1;
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) acc++;
      #1;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_first_diff", bus.diff, 9);
    @(posedge clk);
    #1;
    chk("bp_hold_diff", bus.diff, 9);
    chk("bp_hold_valid", bus.out_valid, 1);

    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (acc < 5);
      bus.x         = W'(10 + acc);
      #1;
      chk("bp_stream_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        chk("bp_order", bus.diff, 9 + got);
        got++;
      end
      rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) acc++;
      #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_out", got, 5);
    chk("bp_drained", bus.out_valid, 0);

    // Reset mid-stream with both stages full
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.x        = 15'd20;
      bus.y        = 15'd1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("mrst_pre_valid", bus.out_valid, 1);
    chk("mrst_pre_in_ready", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_diff", bus.diff, 0);
    chk("mrst_borrow", bus.borrow, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", bus.in_ready, 1);
    chk("mrst_post_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.x         = 15'd5;
    bus.y         = 15'd5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("mrst_no_stale", bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk("mrst_new_valid", bus.out_valid, 1);
    chk("mrst_new_diff", bus.diff, 0);
    chk("mrst_new_borrow", bus.borrow, 0);
    @(posedge clk);
    #1;
    chk("mrst_single", bus.out_valid, 0);

    // Randomized traffic against the queue model
    ec = 0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       begin bus.x = W'($urandom); bus.y = bus.x; end
        1:       begin bus.x = '0;           bus.y = W'($urandom); end
        2:       begin bus.x = W'($urandom); bus.y = 15'h4000; end
        default: begin bus.x = W'($urandom); bus.y = W'($urandom); end
      endcase
      #1;
      exp_v   = (q.size() > 0) && (ec > q[0].e);
      exp_rdy = (q.size() < 2) || bus.out_ready;
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      chk("rnd_out_valid", bus.out_valid, exp_v);
      if (exp_v && bus.out_valid) begin
        chk("rnd_diff", bus.diff, q[0].d);
        chk("rnd_borrow", bus.borrow, q[0].b);
`ifdef SUB_PIPE_OVF_EN
        chk("rnd_ovf", bus.ovf, q[0].o);
`endif
      end
      pop  = exp_v && bus.out_ready;
      push = bus.in_valid && exp_rdy;
      r    = ref_sub(bus.x, bus.y);
      @(posedge clk);
      ec++;
      if (pop) void'(q.pop_front());
      if (push) begin
        r.e = ec;
        q.push_back(r);
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
